// File: rtl/uart_word_receiver_if.sv
// RAM write bus and status flags of the UART word receiver.
// master = receiver, slave = RAM/consumer side.
interface uart_word_receiver_if;
  logic [9:0]  ram_address;
  logic [39:0] ram_data;
  logic        ram_wren;
  logic [9:0]  word_count;
  logic        busy;
  logic        frame_done;
  logic        framing_error;

  modport master (
    output ram_address, ram_data, ram_wren,
    output word_count, busy, frame_done, framing_error
  );

  modport slave (
    input ram_address, ram_data, ram_wren,
    input word_count, busy, frame_done, framing_error
  );
endinterface

// File: rtl/uart_word_receiver.sv
// 8N1 UART receiver packing five bytes per 40-bit RAM word.
// Optional macro RX_TIMEOUT_EN: drop a stale partial word.
module uart_word_receiver #(
  parameter int CLKS_PER_BIT = 868,
  parameter int WORDS        = 540
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rxd,
  uart_word_receiver_if.master bus
);

  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);
  localparam logic [9:0] LAST = 10'(WORDS - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state, state_nx;
  logic          rx_s1, rx_s2, rx_d;
  logic          fall, tick;
  logic [CW-1:0] cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    sh;
  logic [2:0]    idx;
  logic [31:0]   word_lo;
  logic          byte_ok, byte_bad;
  logic          to_hit;

  assign fall = rx_d & ~rx_s2;
  assign tick = (state == START) ? (cnt == HALF)
              : (state != IDLE) && (cnt == FULL);
  assign byte_ok  = (state == STOP) && tick && rx_s2;
  assign byte_bad = (state == STOP) && tick && !rx_s2;

  // Two-flop synchronizer plus one delay flop for edge detection.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
      rx_d  <= 1'b1;
    end else begin
      rx_s1 <= rxd;
      rx_s2 <= rx_s1;
      rx_d  <= rx_s2;
    end
  end

  // FSM state register.
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  // FSM next-state logic.
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:  if (fall) state_nx = START;
      START: if (tick) state_nx = rx_s2 ? IDLE : DATA;
      DATA:  if (tick && bit_cnt == 3'd7) state_nx = STOP;
      STOP:  if (tick) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    bus.busy = (state != IDLE);
  end

  // Bit timing and data shift register (LSB arrives first).
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt     <= '0;
      bit_cnt <= '0;
      sh      <= '0;
    end else begin
      if (state == IDLE || tick) cnt <= '0;
      else                       cnt <= cnt + 1'b1;
      if (state == IDLE) begin
        bit_cnt <= '0;
      end else if (state == DATA && tick) begin
        sh      <= {rx_s2, sh[7:1]};
        bit_cnt <= bit_cnt + 1'b1;
      end
    end
  end

`ifdef RX_TIMEOUT_EN
  localparam logic [31:0] TO_LIM = 32'(20 * CLKS_PER_BIT);
  logic [31:0] to_cnt;

  assign to_hit = (to_cnt == TO_LIM);

  // Idle-time counter while a partial word is pending.
  always_ff @(posedge clk) begin
    if (reset)                            to_cnt <= '0;
    else if (state == IDLE && idx != '0) to_cnt <= to_cnt + 1'b1;
    else                                  to_cnt <= '0;
  end
`else
  assign to_hit = 1'b0;
`endif

  // Word assembly, RAM strobe and status flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      idx               <= '0;
      word_lo           <= '0;
      bus.ram_address   <= '0;
      bus.ram_data      <= '0;
      bus.ram_wren      <= 1'b0;
      bus.word_count    <= '0;
      bus.frame_done    <= 1'b0;
      bus.framing_error <= 1'b0;
    end else begin
      bus.ram_wren <= 1'b0;
      if (bus.ram_wren) begin
        bus.word_count <= bus.word_count + 1'b1;
        if (bus.word_count == LAST) bus.frame_done <= 1'b1;
      end
      if (byte_bad) begin
        bus.framing_error <= 1'b1;
        idx               <= '0;
      end else if (byte_ok) begin
        if (idx == 3'd4) begin
          idx <= '0;
          if (!bus.frame_done) begin
            bus.ram_wren    <= 1'b1;
            bus.ram_data    <= {sh, word_lo};
            bus.ram_address <= bus.word_count;
          end
        end else begin
          word_lo[{idx[1:0], 3'b000} +: 8] <= sh;
          idx <= idx + 1'b1;
        end
      end else if (to_hit) begin
        idx     <= '0;
        word_lo <= '0;
      end
    end
  end

endmodule
